// File: rtl/oven_countdown_timer.sv
// MM:SS oven countdown timer: button-set setpoint with auto-repeat, run/abort switch,
// alarm at 00:00, four active-low 7-segment digits. Single clock, clock-enable style.
module oven_countdown_timer #(
  parameter int TICK_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int STEP_SEC      = 5,
  parameter int MAX_MIN       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_clear_n,
  input  logic       run_sw,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic       running,
  output logic       alarm,
  output logic       tick
);

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_DONE} state_e;

  localparam int              PW         = $clog2(TICK_CYCLES);
  localparam int              RW         = $clog2(REPEAT_CYCLES);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0]   REP_LAST   = RW'(REPEAT_CYCLES - 1);
  localparam logic [5:0]      STEP       = 6'(STEP_SEC);
  localparam logic [6:0]      MIN_MAX    = 7'(MAX_MIN);

  // ---------------------------------------------------------------------------
  // Input synchronisers, order {up_n, down_n, clear_n, run_sw}; idle values on reset
  // ---------------------------------------------------------------------------
  logic [3:0] sync_meta;
  logic [3:0] sync_q;

  // NOTE: every register is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 4'b1110;
      sync_q    <= 4'b1110;
    end else begin
      sync_meta <= {btn_up_n, btn_down_n, btn_clear_n, run_sw};
      sync_q    <= sync_meta;
    end
  end

  logic up_held, down_held, clear_act, run_s;
  logic only_up, only_down, any_press, rep_fire;
  logic up_held_q, down_held_q, run_q;
  logic step_up_q, step_down_q, run_rise_q;
  logic [RW-1:0] rep_cnt;

  assign up_held   = ~sync_q[3];
  assign down_held = ~sync_q[2];
  assign clear_act = ~sync_q[1];
  assign run_s     =  sync_q[0];
  assign only_up   = up_held & ~down_held;
  assign only_down = down_held & ~up_held;
  assign any_press = (only_up & ~up_held_q) | (only_down & ~down_held_q);
  assign rep_fire  = (only_up | only_down) & ~any_press & (rep_cnt == REP_LAST);

  // Step requests are registered, adding the third cycle of press-to-setpoint latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_held_q   <= 1'b0;
      down_held_q <= 1'b0;
      run_q       <= 1'b0;
      rep_cnt     <= '0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      run_rise_q  <= 1'b0;
    end else begin
      up_held_q   <= up_held;
      down_held_q <= down_held;
      run_q       <= run_s;
      run_rise_q  <= run_s & ~run_q;
      step_up_q   <= only_up & ((only_up & ~up_held_q) | rep_fire);
      step_down_q <= only_down & ((only_down & ~down_held_q) | rep_fire);
      if (!(only_up || only_down) || any_press || rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Time arithmetic on binary {min, sec}
  // ---------------------------------------------------------------------------
  function automatic logic [12:0] inc_step(input logic [6:0] m, input logic [5:0] s);
    logic [6:0] sum;
    sum = {1'b0, s} + {1'b0, STEP};
    if (sum < 7'd60)      return {m, sum[5:0]};
    else if (m < MIN_MAX) return {m + 7'd1, 6'd0};
    else                  return {m, s};
  endfunction

  function automatic logic [12:0] dec_step(input logic [6:0] m, input logic [5:0] s);
    if (s >= STEP)     return {m, s - STEP};
    else if (m != '0)  return {m - 7'd1, 6'd60 - STEP};
    else               return {m, s};
  endfunction

  function automatic logic [12:0] count_down(input logic [6:0] m, input logic [5:0] s);
    if (s != '0) return {m, s - 6'd1};
    else         return {m - 7'd1, 6'd59};
  endfunction

  state_e        state;
  logic [6:0]    set_min, rem_min;
  logic [5:0]    set_sec, rem_sec;
  logic [PW-1:0] presc;
  logic [12:0]   set_inc, set_dec, rem_next;
  logic          set_nonzero, rem_last;

  assign set_inc     = inc_step(set_min, set_sec);
  assign set_dec     = dec_step(set_min, set_sec);
  assign rem_next    = count_down(rem_min, rem_sec);
  assign set_nonzero = (set_min != '0) || (set_sec != '0);
  assign rem_last    = (rem_min == '0) && (rem_sec == 6'd1);

  // ---------------------------------------------------------------------------
  // Mode FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SET;
      set_min <= '0;
      set_sec <= '0;
      rem_min <= '0;
      rem_sec <= '0;
      presc   <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        ST_SET: begin
          if (clear_act) begin
            set_min <= '0;
            set_sec <= '0;
          end else if (step_up_q) begin
            {set_min, set_sec} <= set_inc;
          end else if (step_down_q) begin
            {set_min, set_sec} <= set_dec;
          end
          if (run_rise_q && set_nonzero) begin
            rem_min <= set_min;
            rem_sec <= set_sec;
            presc   <= '0;
            running <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!run_s) begin
            // Abort takes priority over a coincident final tick.
            running <= 1'b0;
            state   <= ST_SET;
          end else if (presc == PRESC_LAST) begin
            presc              <= '0;
            tick               <= 1'b1;
            {rem_min, rem_sec} <= rem_next;
            if (rem_last) begin
              running <= 1'b0;
              alarm   <= 1'b1;
              state   <= ST_DONE;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        ST_DONE: begin
          if (!run_s) begin
            alarm <= 1'b0;
            state <= ST_SET;
          end
        end
        default: state <= ST_SET;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------------
  logic [6:0] disp_min;
  logic [5:0] disp_sec;

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    disp_min = '0;
    disp_sec = '0;
    if (state == ST_SET) begin
      disp_min = set_min;
      disp_sec = set_sec;
    end else if (state == ST_RUN) begin
      disp_min = rem_min;
      disp_sec = rem_sec;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign seg3 = seg7(4'(disp_min / 7'd10));
  assign seg2 = seg7(4'(disp_min % 7'd10));
  assign seg1 = seg7(4'(disp_sec / 6'd10));
  assign seg0 = seg7(4'(disp_sec % 6'd10));

endmodule

// File: tb/tb_oven_countdown_timer.sv
// Directed bench for oven_countdown_timer: table of button sequences plus
// hand-written auto-repeat, saturation, countdown, abort and reset sequences.
module tb_oven_countdown_timer;

  logic clk = 1'b0;
  logic rst, btn_up_n, btn_down_n, btn_clear_n, run_sw;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic running, alarm, tick;
  logic [27:0] disp;

  int vectors = 0;
  int miscompares = 0;

  oven_countdown_timer #(
    .TICK_CYCLES(10), .REPEAT_CYCLES(4), .STEP_SEC(5), .MAX_MIN(99)
  ) dut (
    .clk(clk), .rst(rst), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .btn_clear_n(btn_clear_n), .run_sw(run_sw), .seg0(seg0), .seg1(seg1),
    .seg2(seg2), .seg3(seg3), .running(running), .alarm(alarm), .tick(tick)
  );

  always #5 clk = ~clk;
  assign disp = {seg3, seg2, seg1, seg0};

  typedef enum {OP_UP, OP_DOWN, OP_CLEAR} op_e;
  typedef struct {
    op_e op;
    int  count;
    int  exp_min;
    int  exp_sec;
  } vec_t;

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] disp_exp(input int m, input int s);
    return {seg_exp(m / 10), seg_exp(m % 10), seg_exp(s / 10), seg_exp(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int m, input int s);
    check(name, 32'(disp), 32'(disp_exp(m, s)));
  endtask

  task automatic press(input op_e op);
    @(negedge clk);
    case (op)
      OP_UP:    btn_up_n = 1'b0;
      OP_DOWN:  btn_down_n = 1'b0;
      default:  btn_clear_n = 1'b0;
    endcase
    repeat (2) @(negedge clk);
    btn_up_n = 1'b1; btn_down_n = 1'b1; btn_clear_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_running(input string name);
    int n;
    n = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(running), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{OP_UP,    12,  1,  0};
    vecs[1] = '{OP_DOWN,   1,  0, 55};
    vecs[2] = '{OP_DOWN,  11,  0,  0};
    vecs[3] = '{OP_DOWN,   2,  0,  0};
    vecs[4] = '{OP_UP,     3,  0, 15};
    vecs[5] = '{OP_CLEAR,  1,  0,  0};
    vecs[6] = '{OP_UP,    13,  1,  5};
    vecs[7] = '{OP_CLEAR,  1,  0,  0};

    rst = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1; btn_clear_n = 1'b1; run_sw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_time("reset display", 0, 0);
    check("reset running", 32'(running), 32'd0);
    check("reset alarm", 32'(alarm), 32'd0);
    check("reset tick", 32'(tick), 32'd0);

    // Table-driven setpoint stepping
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < vecs[i].count; k++) press(vecs[i].op);
      check_time($sformatf("vec%0d setpoint", i), vecs[i].exp_min, vecs[i].exp_sec);
      check($sformatf("vec%0d running", i), 32'(running), 32'd0);
    end

    // Auto-repeat: first step at +3, then every 4 cycles, held for 40 cycles
    @(negedge clk);
    btn_up_n = 1'b0;
    repeat (3) @(negedge clk);
    check_time("repeat before first step", 0, 0);
    @(negedge clk);
    check_time("repeat first step", 0, 5);
    repeat (3) @(negedge clk);
    check_time("repeat before second step", 0, 5);
    @(negedge clk);
    check_time("repeat second step", 0, 10);
    repeat (32) @(negedge clk);
    check_time("repeat 10 steps", 0, 50);
    btn_up_n = 1'b1;
    repeat (6) @(negedge clk);
    check_time("repeat after release", 0, 50);

    // Saturation at 99:55
    btn_up_n = 1'b0;
    repeat (5000) @(negedge clk);
    btn_up_n = 1'b1;
    repeat (6) @(negedge clk);
    check_time("saturate hold", 99, 55);
    press(OP_UP);
    check_time("saturate press", 99, 55);
    btn_up_n = 1'b0; btn_down_n = 1'b0;
    repeat (20) @(negedge clk);
    btn_up_n = 1'b1; btn_down_n = 1'b1;
    repeat (6) @(negedge clk);
    check_time("both held", 99, 55);
    press(OP_CLEAR);
    for (int k = 0; k < 13; k++) press(OP_UP);
    check_time("countdown setpoint", 1, 5);

    // Countdown from 01:05
    run_sw = 1'b1;
    repeat (3) @(negedge clk);
    check("running before +3", 32'(running), 32'd0);
    @(negedge clk);
    check("running at +3", 32'(running), 32'd1);
    check_time("run display start", 1, 5);
    begin
      int last, ticks, rem_s;
      bit done;
      last = 0; ticks = 0; rem_s = 65; done = 1'b0;
      for (int c = 1; c <= 800 && !done; c++) begin
        @(negedge clk);
        if (tick) begin
          ticks++;
          rem_s--;
          check($sformatf("tick %0d spacing", ticks), 32'(c - last), 32'd10);
          check_time($sformatf("tick %0d display", ticks), rem_s / 60, rem_s % 60);
          last = c;
        end
        if (alarm) begin
          done = 1'b1;
          check("alarm tick count", 32'(ticks), 32'd65);
          check("running at alarm", 32'(running), 32'd0);
          check_time("done display", 0, 0);
        end
      end
      if (!done) check("countdown timeout", 32'd0, 32'd1);
    end
    repeat (5) @(negedge clk);
    check("alarm held in done", 32'(alarm), 32'd1);
    run_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("alarm cleared", 32'(alarm), 32'd0);
    check_time("setpoint after done", 1, 5);

    // Abort mid-run
    run_sw = 1'b1;
    wait_running("abort run start");
    repeat (25) @(negedge clk);
    check_time("abort mid-run display", 1, 3);
    run_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("abort running", 32'(running), 32'd0);
    check("abort alarm", 32'(alarm), 32'd0);
    check_time("abort setpoint kept", 1, 5);

    // Zero-setpoint start stays in SET
    press(OP_CLEAR);
    run_sw = 1'b1;
    repeat (8) @(negedge clk);
    check("zero start running", 32'(running), 32'd0);
    check_time("zero start display", 0, 0);
    run_sw = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-run at 00:30
    for (int k = 0; k < 7; k++) press(OP_UP);
    run_sw = 1'b1;
    wait_running("reset-test run start");
    begin
      int ticks;
      ticks = 0;
      for (int c = 0; c < 200 && ticks < 5; c++) begin
        @(negedge clk);
        if (tick) ticks++;
      end
      check("reset-test tick count", 32'(ticks), 32'd5);
    end
    check_time("mid-run 00:30", 0, 30);
    rst = 1'b1;
    @(negedge clk);
    check_time("mid-run reset display", 0, 0);
    check("mid-run reset running", 32'(running), 32'd0);
    check("mid-run reset tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("tick quiet after reset", 32'(tick), 32'd0);
    end
    check("running after reset", 32'(running), 32'd0);
    run_sw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oven_countdown_timer.md
# oven_countdown_timer

Parametrised MM:SS countdown timer for the oven controller. It replaces the divided-clock timer with a single-clock design built on clock enables. Up/down buttons with auto-repeat set the cook time, a run switch starts and aborts the countdown, and an alarm output asserts at 00:00. It drives four active-low 7-segment digits directly and exports status to the heater/alarm logic.

## Interface
- TICK_CYCLES, 50000000, clk cycles per countdown second (≥2)
- REPEAT_CYCLES, 10000000, clk cycles between auto-repeat steps while a button is held (≥2)
- STEP_SEC, 5, seconds per button step; must divide 60
- MAX_MIN, 99, maximum settable minutes (1..99)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_up_n  in  1  increment button, active-low, asynchronous to clk
- btn_down_n  in  1  decrement button, active-low, asynchronous
- btn_clear_n  in  1  clear setpoint, active-low, asynchronous
- run_sw  in  1  0 = set mode, 1 = run request, asynchronous
- seg0..seg3  out  7 each  active-low segments {g,f,e,d,c,b,a}; seg0 = seconds ones, seg1 = seconds tens, seg2 = minutes ones, seg3 = minutes tens
- running  out  1  high in RUN
- alarm  out  1  high in DONE
- tick  out  1  one-cycle pulse on each countdown decrement

## Operation
- All four asynchronous inputs pass through 2-flop synchronisers. An edge detector on synchronised run_sw produces run_rise.
- Time is held in binary: min[6:0] (0..MAX_MIN) and sec[5:0] (0..59), for both setpoint (set_*) and remaining (rem_*). BCD digits are produced combinationally with /10 and %10. Segment patterns for 0..9: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- States: SET, RUN, DONE. Reset enters SET with set = rem = 00:00, all counters 0, and running = alarm = tick = 0. The display shows 00:00.
- SET: the display shows the setpoint.
  - Up step: if sec+STEP < 60, then sec += STEP. Otherwise, if min < MAX_MIN, then sec = 0 and min += 1. Otherwise, no change (saturate).
  - Down step: if sec ≥ STEP, then sec −= STEP. Otherwise, if min > 0, then min −= 1 and sec = 60−STEP. At 00:00, no change.
  - Clear (synchronised low) forces the setpoint to 00:00 and has priority over up/down.
  - Step generation for up/down:
    - One step on the press edge.
    - While the button is held, one further step every REPEAT_CYCLES cycles.
    - The repeat counter clears on release.
  - Up and down both held: no step; the repeat counter is held at 0.
  - run_rise with a nonzero setpoint: rem = set, prescaler = 0, go to RUN.
  - run_rise with setpoint 00:00: stay in SET. Another rise is needed after run_sw returns low.
- RUN: the display shows rem; buttons are ignored.
  - The prescaler counts 0..TICK_CYCLES−1. At the terminal count it wraps to 0, pulses tick, and decrements rem.
  - Decrement: if sec > 0, then sec −= 1; else sec = 59 and min −= 1.
  - If the decrement yields 00:00, go to DONE on that same edge.
  - Synchronised run_sw low: go to SET (abort). rem is discarded and set is retained.
- DONE: the display shows 00:00 and alarm = 1. Synchronised run_sw low returns to SET with the setpoint retained.
- rst in any state overrides everything and produces the reset values on the next edge.

## Timing
- Input synchroniser latency is 2 cycles. A button falling before edge N updates the setpoint at edge N+3. Segments follow combinationally from the registers.
- run_sw rising before edge N gives running = 1 after edge N+3.
- The first tick comes TICK_CYCLES cycles after entry to RUN; later ticks are exactly TICK_CYCLES apart.
- A total time of T seconds reaches DONE on the T-th tick; alarm rises on that same edge.
- Auto-repeat: first step at press + 3 cycles, then every REPEAT_CYCLES cycles.
- An abort (run_sw low) on the same cycle as a final tick: the abort wins and the state goes to SET with alarm = 0.
- tick is never asserted outside RUN.

## Test plan
Bench parameters: TICK_CYCLES=10, REPEAT_CYCLES=4, STEP_SEC=5, MAX_MIN=99.
- Reset: assert rst for 2 cycles -> segs = 1000000 ×4, running = alarm = tick = 0, state SET.
- Step and wrap: 12 up presses from 00:00 -> 01:00; one down press -> 00:55; down presses at 00:00 -> stays 00:00.
- Auto-repeat and saturation: hold up for 40 cycles -> first step at +3, then every 4 cycles, 10 steps total = 00:50. Preload 99:55 and press up -> stays 99:55. Up and down both held -> no change.
- Countdown: set 01:05, raise run_sw -> running after 3 cycles. Tick every 10 cycles: 01:04 … 01:00, 00:59 … Then alarm = 1 and running = 0 exactly on the 65th tick, with display 00:00.
- Abort and zero start:
  - During RUN, drop run_sw -> SET within 3 cycles, display shows the setpoint again, no alarm.
  - run_sw rise with a 00:00 setpoint -> stays in SET.
- Reset mid-run: assert rst during RUN at 00:30 -> next edge gives SET, 00:00 display, and tick stays 0.
